mem_arb: RTL and testbench
==========================

# mem_arb

Two-port arbiter and sequencer in front of the single-port synchronous core memory (`mem_wrap`). It shares the memory between the instruction-fetch port (read-only) and the load/store port (read/write with byte enables). It issues at most one memory access per cycle and routes the 1-cycle-latency read data back to the owning requester. Partial-word stores are turned into a read-modify-write sequence.

## Interface
- `ADDR_WIDTH`, 32: word address width; matches the memory's `addr`.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8; `BE_WIDTH = DATA_WIDTH/8`.

Ports:
- `clk  in  1` — single clock, all logic on the rising edge.
- `reset_n  in  1` — reset, asynchronous, active-low.
- `if_req  in  1` — fetch read request.
- `if_addr  in  ADDR_WIDTH` — fetch word address.
- `if_gnt  out  1` — fetch request accepted this cycle.
- `if_rvalid  out  1` — fetch read data valid.
- `if_rdata  out  DATA_WIDTH` — fetch read data.
- `lsu_req  in  1` — load/store request.
- `lsu_we  in  1` — 1 = store, 0 = load.
- `lsu_be  in  BE_WIDTH` — store byte enables.
- `lsu_addr  in  ADDR_WIDTH` — load/store word address.
- `lsu_wdata  in  DATA_WIDTH` — store data.
- `lsu_gnt  out  1` — load/store request accepted.
- `lsu_rvalid  out  1` — load data valid; never asserted for stores.
- `lsu_rdata  out  DATA_WIDTH` — load data.
- `mem_en`, `mem_wr`  out  1 each; `mem_addr`  out  ADDR_WIDTH; `mem_wdata`  out  DATA_WIDTH — memory command.
- `mem_rdata  in  DATA_WIDTH` — memory read data, registered inside the memory, valid the cycle after a read command.

## Operation
- **Handshake:** a requester holds `req` and all attributes stable until it sees `gnt`=1 at a rising edge.
- **Grant timing:** `gnt` is combinational in the issue cycle. The memory command is driven in the same cycle. At most one `gnt` is asserted per cycle.
- **States:** `ARB_IDLE` and `ARB_RMW`.
  - Grants occur only in `ARB_IDLE` and only when the `ready` flop is 1.
  - `ready` resets to 0 and sets on the first edge after reset release.
- **Fetch / load:** `mem_en`=1, `mem_wr`=0. A pending flag records the owner. On the next cycle the owner's `rvalid`=1 and its `rdata` = `mem_rdata`. The non-owner's `rdata` is don't-care.
- **Full store** (`lsu_be` all ones): `mem_en`=1, `mem_wr`=1, `mem_wdata`=`lsu_wdata`. Stays in `ARB_IDLE`.
- **Partial store** (`lsu_be` neither all ones nor zero):
  - Grant cycle: issue a read of `lsu_addr`; latch `addr`/`be`/`wdata`; go to `ARB_RMW`.
  - `ARB_RMW` cycle: write the merge to the latched address, taking byte i from latched `wdata` if `be[i]` else from `mem_rdata`. No grants this cycle. Return to `ARB_IDLE`.
- **Zero-byte store** (`lsu_be`=0): granted, `mem_en`=0, no response.
- **Arbitration default:** fixed priority, LSU over fetch.

## Timing
- **Reset values:** all outputs 0; state `ARB_IDLE`; `ready` 0; pending flags 0; round-robin pointer 0 (favours LSU).
- **Read latency:** 1 cycle, gnt at N gives rvalid at N+1. Back-to-back reads reach 1 access/cycle.
- **Store timing:**
  - Full store updates memory at the end of the grant cycle.
  - Partial store updates memory at the end of N+1, occupying 2 cycles.
  - A read of the same address granted at N+1 (full store) or N+2 (partial store) returns the new data.
- **Simultaneous requests:** one winner per the active policy. The loser sees `gnt`=0 and keeps requesting.
- **Request during `ARB_RMW`:** stalled 1 cycle.
- **Reset mid-operation:** an in-flight RMW write is aborted and memory is not written. Pending `rvalid`s are dropped.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin. When both request, grant the requester not granted last. The pointer updates on every grant, and a single requester is always granted.
- **`MEM_ARB_RR_EN` undefined:** fixed LSU priority; the pointer logic is absent.

## Structure
- **`mem_arb_pkg`:**
  - `arb_state_e` {`ARB_IDLE`, `ARB_RMW`}.
  - `arb_src_e` {`SRC_LSU`, `SRC_IF`}.
  - A byte-merge function (`be`, `new`, `old`).
- **`mem_arb_pick` sub-module:** 2-way picker (req vector in, one-hot grant out). Holds the round-robin pointer under `MEM_ARB_RR_EN`.

## Test plan
- **Reset:** hold `reset_n`=0 with `if_req`=1 → all outputs 0. After release, first `if_gnt` one cycle later.
- **Fetch stream:** `if_req` continuously, `addr` 0..3 preloaded 0x11..0x44 → `if_gnt` every cycle, `if_rdata` 0x11,0x22,0x33,0x44 on consecutive rvalid cycles.
- **Both request every cycle:**
  - Without RR: `lsu_gnt` every cycle, `if_gnt` never.
  - With `MEM_ARB_RR_EN`: grants alternate LSU, IF, LSU…
- **Partial store:** mem[5]=0xAABBCCDD; store be=4'b0101 wdata=0x11223344 → `mem_en` read then write 0xAA22CC44; `if_req` in RMW cycle gets gnt one cycle later. A following load of 5 returns 0xAA22CC44.
- **Full store then load:** store 0xDEADBEEF to addr 7 at N, load 7 at N+1 → `lsu_rdata`=0xDEADBEEF at N+2.
- **Zero-byte store and reset during RMW:**
  - be=0 → gnt, no mem write.
  - `reset_n` low during `ARB_RMW` → target word unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and the byte-merge helper for the mem_arb arbiter slice.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_RMW  = 1'b1
    } arb_state_e;

    // Values double as bit positions in the picker's req/gnt vectors.
    typedef enum logic [0:0] {
        SRC_LSU = 1'b0,
        SRC_IF  = 1'b1
    } arb_src_e;

    localparam int unsigned NUM_SRC = 2;

    function automatic logic [7:0] merge_byte(input logic       be,
                                              input logic [7:0] new_byte,
                                              input logic [7:0] old_byte);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// 2-way request picker: fixed LSU priority, or round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic               clk,
    input  logic               reset_n,
`endif
    input  logic               en,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] gnt
);

`ifdef MEM_ARB_RR_EN
    // 0 favours the LSU on a tie; flips toward whoever was not granted last.
    logic favour_if_q, favour_if_d;

    always_comb begin
        gnt         = '0;
        favour_if_d = favour_if_q;
        if (en) begin
            if (req[SRC_LSU] && (!req[SRC_IF] || !favour_if_q)) begin
                gnt[SRC_LSU] = 1'b1;
            end else if (req[SRC_IF]) begin
                gnt[SRC_IF] = 1'b1;
            end
        end
        if (gnt[SRC_LSU]) begin
            favour_if_d = 1'b1;
        end else if (gnt[SRC_IF]) begin
            favour_if_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            favour_if_q <= 1'b0;
        end else begin
            favour_if_q <= favour_if_d;
        end
    end
`else
    always_comb begin
        gnt = '0;
        if (en) begin
            if (req[SRC_LSU]) begin
                gnt[SRC_LSU] = 1'b1;
            end else if (req[SRC_IF]) begin
                gnt[SRC_IF] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arb.sv
// Fetch/LSU arbiter in front of a single-port 1-cycle-latency memory; partial stores become RMW.
// Optional round-robin arbitration via MEM_ARB_RR_EN (default: fixed LSU priority).
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH = 32,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  lsu_req,
    input  logic                  lsu_we,
    input  logic [BE_WIDTH-1:0]   lsu_be,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_gnt,
    output logic                  lsu_rvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e            state_q, state_d;
    logic                  ready_q;
    logic                  pend_if_q, pend_if_d;
    logic                  pend_lsu_q, pend_lsu_d;
    logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
    logic [BE_WIDTH-1:0]   rmw_be_q, rmw_be_d;
    logic [DATA_WIDTH-1:0] rmw_wdata_q, rmw_wdata_d;
    logic [DATA_WIDTH-1:0] rmw_merged;
    logic [NUM_SRC-1:0]    req, gnt;
    logic                  grant_en;

    assign req[SRC_LSU] = lsu_req;
    assign req[SRC_IF]  = if_req;
    assign grant_en     = ready_q && (state_q == ARB_IDLE);

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .clk     (clk),
        .reset_n (reset_n),
`endif
        .en      (grant_en),
        .req     (req),
        .gnt     (gnt)
    );

    assign lsu_gnt = gnt[SRC_LSU];
    assign if_gnt  = gnt[SRC_IF];

    for (genvar b = 0; b < BE_WIDTH; b++) begin : g_merge
        assign rmw_merged[b*8 +: 8] = merge_byte(rmw_be_q[b], rmw_wdata_q[b*8 +: 8],
                                                 mem_rdata[b*8 +: 8]);
    end

    always_comb begin
        state_d     = state_q;
        pend_if_d   = 1'b0;
        pend_lsu_d  = 1'b0;
        rmw_addr_d  = rmw_addr_q;
        rmw_be_d    = rmw_be_q;
        rmw_wdata_d = rmw_wdata_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (state_q == ARB_RMW) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = rmw_addr_q;
            mem_wdata = rmw_merged;
            state_d   = ARB_IDLE;
        end else if (lsu_gnt) begin
            if (!lsu_we) begin
                mem_en     = 1'b1;
                mem_addr   = lsu_addr;
                pend_lsu_d = 1'b1;
            end else if (&lsu_be) begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = lsu_addr;
                mem_wdata = lsu_wdata;
            end else if (|lsu_be) begin
                // Read the old word now; the merged write goes out next cycle.
                mem_en      = 1'b1;
                mem_addr    = lsu_addr;
                rmw_addr_d  = lsu_addr;
                rmw_be_d    = lsu_be;
                rmw_wdata_d = lsu_wdata;
                state_d     = ARB_RMW;
            end
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            pend_if_d = 1'b1;
        end
    end

    assign if_rvalid  = pend_if_q;
    assign lsu_rvalid = pend_lsu_q;
    assign if_rdata   = pend_if_q ? mem_rdata : '0;
    assign lsu_rdata  = pend_lsu_q ? mem_rdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            ready_q     <= 1'b0;
            pend_if_q   <= 1'b0;
            pend_lsu_q  <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_be_q    <= '0;
            rmw_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            pend_if_q   <= pend_if_d;
            pend_lsu_q  <= pend_lsu_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_be_q    <= rmw_be_d;
            rmw_wdata_q <= rmw_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: behavioural memory, cycle model of grants/commands, directed ops.
module tb_mem_arb;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          lsu_req = 1'b0;
    logic          lsu_we = 1'b0;
    logic [BW-1:0] lsu_be = '0;
    logic [AW-1:0] lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0;
    logic          lsu_gnt, lsu_rvalid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] gm [64];
    logic [DW-1:0] if_q [$];
    logic [DW-1:0] lsu_q [$];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .lsu_be     (lsu_be),
        .lsu_addr   (lsu_addr),
        .lsu_wdata  (lsu_wdata),
        .lsu_gnt    (lsu_gnt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Single-port synchronous memory with registered read data; unaffected by reset.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) env_mem[mem_addr[5:0]] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr[5:0]];
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: what the arbiter must do, in terms of transactions rather than RTL state.
    logic          m_ready = 1'b0;
    logic          m_rmw = 1'b0;
    logic          m_pend_if = 1'b0;
    logic          m_pend_lsu = 1'b0;
    logic          m_favour_if = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [AW-1:0] m_rmw_addr = '0;
    logic [BW-1:0] m_rmw_be = '0;
    logic [DW-1:0] m_rmw_wdata = '0;

    always @(negedge clk) begin : model
        logic          e_if_gnt, e_lsu_gnt, e_en, e_wr, lsu_wins, n_pend_if, n_pend_lsu;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata, mask;
        if (!reset_n) begin
            check("reset ctl outputs", {26'd0, if_gnt, if_rvalid, lsu_gnt, lsu_rvalid, mem_en,
                                        mem_wr}, '0);
            check("reset if_rdata", if_rdata, '0);
            check("reset lsu_rdata", lsu_rdata, '0);
            check("reset mem_addr", mem_addr, '0);
            check("reset mem_wdata", mem_wdata, '0);
            m_ready = 1'b0;
            m_rmw = 1'b0;
            m_pend_if = 1'b0;
            m_pend_lsu = 1'b0;
            m_favour_if = 1'b0;
        end else begin
            e_if_gnt = 1'b0; e_lsu_gnt = 1'b0; e_en = 1'b0; e_wr = 1'b0;
            e_addr = '0; e_wdata = '0; n_pend_if = 1'b0; n_pend_lsu = 1'b0;
            check("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_pend_if});
            check("lsu_rvalid", {31'd0, lsu_rvalid}, {31'd0, m_pend_lsu});
            if (m_pend_if) check("if_rdata", if_rdata, m_data);
            if (m_pend_lsu) check("lsu_rdata", lsu_rdata, m_data);
            if (m_ready && m_rmw) begin
                mask = '0;
                for (int b = 0; b < BW; b++) if (m_rmw_be[b]) mask[b*8 +: 8] = 8'hFF;
                e_en = 1'b1; e_wr = 1'b1; e_addr = m_rmw_addr;
                e_wdata = (m_rmw_wdata & mask) | (gm[m_rmw_addr[5:0]] & ~mask);
                gm[m_rmw_addr[5:0]] = e_wdata;
                m_rmw = 1'b0;
            end else if (m_ready && (lsu_req || if_req)) begin
`ifdef MEM_ARB_RR_EN
                lsu_wins = lsu_req && !(if_req && m_favour_if);
`else
                lsu_wins = lsu_req;
`endif
                if (lsu_wins) begin
                    e_lsu_gnt = 1'b1;
                    m_favour_if = 1'b1;
                    if (!lsu_we) begin
                        e_en = 1'b1; e_addr = lsu_addr; n_pend_lsu = 1'b1;
                        m_data = gm[lsu_addr[5:0]];
                    end else if (lsu_be == {BW{1'b1}}) begin
                        e_en = 1'b1; e_wr = 1'b1; e_addr = lsu_addr; e_wdata = lsu_wdata;
                        gm[lsu_addr[5:0]] = lsu_wdata;
                    end else if (lsu_be != '0) begin
                        e_en = 1'b1; e_addr = lsu_addr; m_rmw = 1'b1;
                        m_rmw_addr = lsu_addr; m_rmw_be = lsu_be; m_rmw_wdata = lsu_wdata;
                    end
                end else begin
                    e_if_gnt = 1'b1;
                    m_favour_if = 1'b0;
                    e_en = 1'b1; e_addr = if_addr; n_pend_if = 1'b1;
                    m_data = gm[if_addr[5:0]];
                end
            end
            check("if_gnt", {31'd0, if_gnt}, {31'd0, e_if_gnt});
            check("lsu_gnt", {31'd0, lsu_gnt}, {31'd0, e_lsu_gnt});
            check("mem_en", {31'd0, mem_en}, {31'd0, e_en});
            check("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
            if (e_en) check("mem_addr", mem_addr, e_addr);
            if (e_wr) check("mem_wdata", mem_wdata, e_wdata);
            m_pend_if = n_pend_if;
            m_pend_lsu = n_pend_lsu;
            m_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && if_rvalid) if_q.push_back(if_rdata);
        if (reset_n && lsu_rvalid) lsu_q.push_back(lsu_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        env_mem[a] = d;
        gm[a] = d;
    endtask

    // Returns after the accepting edge; cycles counts negedges observed up to the grant.
    task automatic wait_gnt(input bit is_lsu, output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cycles++;
            if (is_lsu ? lsu_gnt : if_gnt) begin
                step();
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s timeout: no grant after 20 cycles", is_lsu ? "lsu_gnt" : "if_gnt");
        step();
    endtask

    task automatic lsu_op(input bit we, input logic [BW-1:0] be, input int a,
                          input logic [DW-1:0] wd, output int cycles);
        lsu_req = 1'b1; lsu_we = we; lsu_be = be; lsu_addr = AW'(a); lsu_wdata = wd;
        wait_gnt(1'b1, cycles);
        lsu_req = 1'b0;
    endtask

    task automatic fetch(input int a, output int cycles);
        if_req = 1'b1;
        if_addr = AW'(a);
        wait_gnt(1'b0, cycles);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int c;
        logic [DW-1:0] exp_fetch [4];
        logic lg [6];
        logic ig [6];
        exp_fetch = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 64; i++) preload(i, '0);
        for (int i = 0; i < 4; i++) preload(i, exp_fetch[i]);

        // Reset held with a fetch request pending.
        if_req = 1'b1;
        if_addr = '0;
        repeat (3) @(negedge clk);
        check("reset if_gnt", {31'd0, if_gnt}, '0);
        step();
        reset_n = 1'b1;

        // Fetch stream 0..3.
        fetch(0, c);
        check("first if_gnt latency", c, 2);
        fetch(1, c);
        check("stream if_gnt latency", c, 1);
        fetch(2, c);
        fetch(3, c);
        if_req = 1'b0;
        repeat (2) step();
        check("fetch count", if_q.size(), 4);
        for (int i = 0; i < 4 && i < if_q.size(); i++) check("fetch data", if_q[i], exp_fetch[i]);

        // Both request every cycle.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = '1; lsu_addr = 2;
        if_req = 1'b1; if_addr = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lg[i] = lsu_gnt;
            ig[i] = if_gnt;
        end
        step();
        lsu_req = 1'b0;
        if_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
            check($sformatf("both lsu_gnt[%0d]", i), {31'd0, lg[i]}, (i % 2 == 0) ? 1 : 0);
            check($sformatf("both if_gnt[%0d]", i), {31'd0, ig[i]}, (i % 2 == 1) ? 1 : 0);
`else
            check($sformatf("both lsu_gnt[%0d]", i), {31'd0, lg[i]}, 1);
            check($sformatf("both if_gnt[%0d]", i), {31'd0, ig[i]}, 0);
`endif
        end
        repeat (2) step();
        if_q.delete();
        lsu_q.delete();

        // Partial store with a fetch arriving during the RMW cycle.
        preload(5, 32'hAABBCCDD);
        lsu_op(1'b1, 4'b0101, 5, 32'h11223344, c);
        if_req = 1'b1;
        if_addr = 3;
        @(negedge clk);
        check("rmw mem_wr", {31'd0, mem_wr}, 1);
        check("rmw mem_wdata", mem_wdata, 32'hAA22CC44);
        check("rmw if_gnt stalled", {31'd0, if_gnt}, 0);
        @(negedge clk);
        check("if_gnt after rmw", {31'd0, if_gnt}, 1);
        step();
        if_req = 1'b0;
        lsu_op(1'b0, 4'hF, 5, '0, c);
        repeat (2) step();
        check("partial load count", lsu_q.size(), 1);
        if (lsu_q.size() > 0) check("partial load data", lsu_q[0], 32'hAA22CC44);
        lsu_q.delete();

        // Full store then load of the same address on the next cycle.
        lsu_op(1'b1, 4'hF, 7, 32'hDEADBEEF, c);
        lsu_op(1'b0, 4'hF, 7, '0, c);
        check("load after store latency", c, 1);
        repeat (2) step();
        check("full load count", lsu_q.size(), 1);
        if (lsu_q.size() > 0) check("full load data", lsu_q[0], 32'hDEADBEEF);
        lsu_q.delete();

        // Zero-byte store: granted, no write, no response.
        preload(8, 32'h5555AAAA);
        lsu_op(1'b1, 4'h0, 8, 32'h12345678, c);
        repeat (3) step();
        check("zero-byte mem unchanged", env_mem[8], 32'h5555AAAA);
        check("zero-byte no rvalid", lsu_q.size(), 0);

        // Reset asserted during the RMW cycle aborts the write.
        preload(9, 32'h01020304);
        lsu_op(1'b1, 4'b0011, 9, 32'hFFFFFFFF, c);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        check("rmw reset mem unchanged", env_mem[9], 32'h01020304);
        lsu_op(1'b0, 4'hF, 9, '0, c);
        repeat (2) step();
        check("rmw reset load count", lsu_q.size(), 1);
        if (lsu_q.size() > 0) check("rmw reset load data", lsu_q[0], 32'h01020304);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
